// File: rtl/seg7_mux_reader.sv
// Receiver for the two-digit multiplexed 7-segment bus {cat, segs}: synchronises the bus,
// waits for each digit phase to settle, decodes glyphs to nibbles and assembles a byte.
module seg7_mux_reader #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 8
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic [6:0] segs,
    input  logic       cat,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic       valid0,
    output logic       valid1,
    output logic [7:0] pair,
    output logic       pair_strb,
    output logic       err,
    output logic       state_dbg
);

    typedef enum logic {
        SEEK0 = 1'b0,
        HAVE0 = 1'b1
    } state_t;

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0] STABLE_PRE = 8'(STABLE_CYCLES - 1);

    // Returns {hit, value}; hit is 0 for blank and for any non-hex pattern.
    function automatic logic [4:0] glyph_decode(input logic [6:0] g);
        logic [4:0] r;
        case (g)
            7'h3F:   r = {1'b1, 4'h0};
            7'h06:   r = {1'b1, 4'h1};
            7'h5B:   r = {1'b1, 4'h2};
            7'h4F:   r = {1'b1, 4'h3};
            7'h66:   r = {1'b1, 4'h4};
            7'h6D:   r = {1'b1, 4'h5};
            7'h7D:   r = {1'b1, 4'h6};
            7'h07:   r = {1'b1, 4'h7};
            7'h7F:   r = {1'b1, 4'h8};
            7'h6F:   r = {1'b1, 4'h9};
            7'h77:   r = {1'b1, 4'hA};
            7'h7C:   r = {1'b1, 4'hB};
            7'h39:   r = {1'b1, 4'hC};
            7'h5E:   r = {1'b1, 4'hD};
            7'h79:   r = {1'b1, 4'hE};
            7'h71:   r = {1'b1, 4'hF};
            default: r = 5'd0;
        endcase
        return r;
    endfunction

    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] sync_d [SYNC_STAGES];
    logic [7:0] cnt_q, cnt_d;
    state_t     state_q, state_d;
    logic [3:0] digit0_q, digit0_d, digit1_q, digit1_d;
    logic       valid0_q, valid0_d, valid1_q, valid1_d;
    logic [7:0] pair_q, pair_d;
    logic       pair_strb_q, pair_strb_d;
    logic       err_q, err_d;

    logic [7:0] bus_s;
    logic [7:0] bus_nxt;
    logic       same;
    logic       capture;
    logic [4:0] dec;
    logic       blank;

    // bus_nxt is the value bus_s takes at the next edge, so the counter clears on the
    // same edge that bus_s changes and capture lands SYNC_STAGES+STABLE_CYCLES edges after the pins.
    assign bus_s   = sync_q[SYNC_STAGES-1];
    assign bus_nxt = sync_q[SYNC_STAGES-2];
    assign same    = (bus_nxt == bus_s);
    assign capture = same && (cnt_q == STABLE_PRE);
    assign dec     = glyph_decode(bus_s[6:0]);
    assign blank   = (bus_s[6:0] == 7'd0);

    always_comb begin
        sync_d[0] = {cat, segs};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        state_d     = state_q;
        digit0_d    = digit0_q;
        digit1_d    = digit1_q;
        valid0_d    = valid0_q;
        valid1_d    = valid1_q;
        pair_d      = pair_q;
        pair_strb_d = 1'b0;
        err_d       = 1'b0;

        if (!same) begin
            cnt_d = 8'd0;
        end else if (cnt_q < STABLE_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end

        if (capture) begin
            if (dec[4]) begin
                if (bus_s[7]) begin
                    digit1_d = dec[3:0];
                    valid1_d = 1'b1;
                end else begin
                    digit0_d = dec[3:0];
                    valid0_d = 1'b1;
                end
            end else begin
                if (bus_s[7]) valid1_d = 1'b0;
                else          valid0_d = 1'b0;
                err_d = !blank;
            end

            case (state_q)
                SEEK0: begin
                    if (dec[4] && !bus_s[7]) state_d = HAVE0;
                end
                HAVE0: begin
                    if (!dec[4]) begin
                        state_d = SEEK0;
                    end else if (bus_s[7]) begin
                        pair_d      = {dec[3:0], digit0_q};
                        pair_strb_d = 1'b1;
                        state_d     = SEEK0;
                    end
                end
                default: state_d = SEEK0;
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 8'd0;
            end
            cnt_q       <= 8'd0;
            state_q     <= SEEK0;
            digit0_q    <= 4'd0;
            digit1_q    <= 4'd0;
            valid0_q    <= 1'b0;
            valid1_q    <= 1'b0;
            pair_q      <= 8'd0;
            pair_strb_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            digit0_q    <= digit0_d;
            digit1_q    <= digit1_d;
            valid0_q    <= valid0_d;
            valid1_q    <= valid1_d;
            pair_q      <= pair_d;
            pair_strb_q <= pair_strb_d;
            err_q       <= err_d;
        end
    end

    assign digit0    = digit0_q;
    assign digit1    = digit1_q;
    assign valid0    = valid0_q;
    assign valid1    = valid1_q;
    assign pair      = pair_q;
    assign pair_strb = pair_strb_q;
    assign err       = err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_seg7_mux_reader.sv
// Bench for seg7_mux_reader: directed phases plus random bus traffic, every cycle
// compared against an edge-history reference model of the receiver.
module tb_seg7_mux_reader;

    localparam int S      = 2;
    localparam int STABLE = 8;
    localparam int MAXE   = 32768;

    localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic       sysclk = 1'b0;
    logic       rst    = 1'b1;
    logic [6:0] segs   = 7'd0;
    logic       cat    = 1'b0;
    logic [3:0] digit0, digit1;
    logic       valid0, valid1;
    logic [7:0] pair;
    logic       pair_strb, err, state_dbg;

    always #4 sysclk = ~sysclk;

    seg7_mux_reader #(.SYNC_STAGES(S), .STABLE_CYCLES(STABLE)) dut (
        .sysclk    (sysclk),
        .rst       (rst),
        .segs      (segs),
        .cat       (cat),
        .digit0    (digit0),
        .digit1    (digit1),
        .valid0    (valid0),
        .valid1    (valid1),
        .pair      (pair),
        .pair_strb (pair_strb),
        .err       (err),
        .state_dbg (state_dbg)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: the synchronised bus at edge n is the pin value sampled S-1 edges
    // earlier (zero if a reset intervened); a capture happens STABLE edges after it last
    // changed or was reset.
    logic [7:0] hist [MAXE];
    int         edge_n    = 0;
    int         last_rst  = -1000;
    int         run_start = 0;
    logic [7:0] d_prev    = 8'd0;
    logic [3:0] m_d0 = 4'd0, m_d1 = 4'd0;
    logic       m_v0 = 1'b0, m_v1 = 1'b0;
    logic [7:0] m_pair = 8'd0;
    logic       m_strb = 1'b0, m_err = 1'b0, m_have0 = 1'b0;
    int         strb_seen = 0;
    int         err_seen  = 0;

    function automatic int glyph_index(input logic [6:0] g);
        for (int i = 0; i < 16; i++) begin
            if (GLYPH[i] == g) return i;
        end
        return -1;
    endfunction

    task automatic model_edge();
        logic [7:0] d;
        int         idx;
        m_strb = 1'b0;
        m_err  = 1'b0;
        if (rst) begin
            last_rst  = edge_n;
            run_start = edge_n;
            d_prev    = 8'd0;
            m_d0 = 4'd0; m_d1 = 4'd0; m_v0 = 1'b0; m_v1 = 1'b0;
            m_pair = 8'd0; m_have0 = 1'b0;
        end else begin
            d = (edge_n - S + 1 > last_rst) ? hist[edge_n-S+1] : 8'h00;
            if (d !== d_prev) run_start = edge_n;
            d_prev = d;
            if (edge_n - run_start == STABLE) begin
                idx = glyph_index(d[6:0]);
                if (idx >= 0) begin
                    if (d[7]) begin
                        m_d1 = idx[3:0];
                        m_v1 = 1'b1;
                        if (m_have0) begin
                            m_pair = {idx[3:0], m_d0};
                            m_strb = 1'b1;
                        end
                        m_have0 = 1'b0;
                    end else begin
                        m_d0    = idx[3:0];
                        m_v0    = 1'b1;
                        m_have0 = 1'b1;
                    end
                end else begin
                    if (d[7]) m_v1 = 1'b0;
                    else      m_v0 = 1'b0;
                    m_err   = (d[6:0] != 7'd0);
                    m_have0 = 1'b0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge sysclk);
        if (edge_n >= MAXE) begin
            $display("FAIL edge_budget: got %0d expected < %0d", edge_n, MAXE);
            $fatal(1, "edge budget exhausted");
        end
        hist[edge_n] = {cat, segs};
        model_edge();
        edge_n++;
        #1;
        check_val("outs", {12'd0, digit1, digit0, valid1, valid0, pair, pair_strb, err, state_dbg},
                  {12'd0, m_d1, m_d0, m_v1, m_v0, m_pair, m_strb, m_err, m_have0});
        check_val("strb_err_excl", {31'd0, pair_strb & err}, 32'd0);
        if (pair_strb) strb_seen++;
        if (err) err_seen++;
    endtask

    task automatic phase(input logic c, input logic [6:0] s, input int n);
        cat  = c;
        segs = s;
        repeat (n) step();
    endtask

    int lat;
    int r;
    logic [6:0] rs;

    initial begin
        // T1 reset with random bus, then blank bus
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cat  = 1'($urandom);
            segs = 7'($urandom);
            step();
        end
        check_val("t1_reset", {12'd0, digit1, digit0, valid1, valid0, pair, pair_strb, err, state_dbg}, 32'd0);
        rst = 1'b0;
        err_seen = 0;
        phase(1'b0, 7'h00, 20);
        check_val("t1_valid", {30'd0, valid1, valid0}, 32'd0);
        check_val("t1_err", err_seen, 0);

        // T2 normal pair with exact latency
        strb_seen = 0;
        cat = 1'b0; segs = 7'h4F; lat = 0;
        for (int k = 1; k <= 32; k++) begin
            step();
            if (lat == 0 && valid0) lat = k;
        end
        check_val("t2_lat0", lat, S + STABLE);
        check_val("t2_digit0", {28'd0, digit0}, 32'h3);
        cat = 1'b1; segs = 7'h66; lat = 0;
        for (int k = 1; k <= 32; k++) begin
            step();
            if (lat == 0 && pair_strb) lat = k;
        end
        check_val("t2_lat1", lat, S + STABLE);
        check_val("t2_pair", {24'd0, pair}, 32'h43);
        check_val("t2_strb_count", strb_seen, 1);

        // T3 invalid glyph on digit1
        strb_seen = 0; err_seen = 0;
        phase(1'b0, 7'h3F, 32);
        phase(1'b1, 7'h49, 32);
        check_val("t3_err_count", err_seen, 1);
        check_val("t3_valid1", {31'd0, valid1}, 32'd0);
        check_val("t3_digit1", {28'd0, digit1}, 32'h4);
        check_val("t3_strb_count", strb_seen, 0);
        check_val("t3_state", {31'd0, state_dbg}, 32'd0);

        // T4 short glitch phase is rejected
        strb_seen = 0;
        phase(1'b0, 7'h06, 32);
        phase(1'b1, 7'h7F, 5);
        phase(1'b0, 7'h06, 32);
        check_val("t4_digit1", {28'd0, digit1}, 32'h4);
        check_val("t4_valid1", {31'd0, valid1}, 32'd0);
        check_val("t4_digit0", {27'd0, valid0, digit0}, 32'h11);
        check_val("t4_strb_count", strb_seen, 0);

        // T5 digit1 first after reset, then blank drops valid0
        rst = 1'b1; step(); step(); rst = 1'b0;
        strb_seen = 0;
        phase(1'b1, 7'h5B, 32);
        check_val("t5_digit1", {27'd0, valid1, digit1}, 32'h12);
        check_val("t5_strb_count", strb_seen, 0);
        phase(1'b0, 7'h6D, 32);
        err_seen = 0;
        phase(1'b0, 7'h00, 32);
        check_val("t5_blank", {27'd0, valid0, digit0}, 32'h05);
        check_val("t5_err_count", err_seen, 0);

        // T6 reset between halves of a pair
        phase(1'b0, 7'h07, 32);
        check_val("t6_have0", {31'd0, state_dbg}, 32'd1);
        rst = 1'b1; step(); rst = 1'b0;
        strb_seen = 0;
        phase(1'b1, 7'h7D, 32);
        check_val("t6_no_strb", strb_seen, 0);
        check_val("t6_digit1", {28'd0, digit1}, 32'h6);
        phase(1'b0, 7'h77, 32);
        phase(1'b1, 7'h7C, 32);
        check_val("t6_strb_count", strb_seen, 1);
        check_val("t6_pair", {24'd0, pair}, 32'hBA);

        // Random phases: hex glyphs, blanks, junk patterns, short glitches, resets
        for (int p = 0; p < 150; p++) begin
            r = int'($urandom_range(0, 99));
            if (r < 60)      rs = GLYPH[$urandom_range(0, 15)];
            else if (r < 75) rs = 7'h00;
            else             rs = 7'($urandom);
            if ($urandom_range(0, 99) < 3) begin
                rst = 1'b1; step(); rst = 1'b0;
            end
            phase(1'($urandom), rs, int'($urandom_range(1, 40)));
        end
        phase(1'b0, 7'h00, 20);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
